// File: rtl/hamming_checker_pkg.sv
// Shared definitions for the SECDED checker: width derivations, error classes
// and the codeword position of each data bit.
package hamming_checker_pkg;

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        SINGLE = 2'd1,
        DOUBLE = 2'd2
    } err_class_e;

    function automatic int cw_width(input int p_bits);
        return 1 << p_bits;
    endfunction

    function automatic int data_width(input int p_bits);
        return (1 << p_bits) - p_bits - 1;
    endfunction

    // Codeword index of data bit k: the k-th non-power-of-two position >= 3.
    function automatic int data_pos(input int p_bits, input int k);
        int seen;
        int pos;
        seen = 0;
        pos  = 0;
        for (int i = 3; i < (1 << p_bits); i++) begin
            if ((i & (i - 1)) != 0) begin
                if (seen == k) pos = i;
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_checker_if.sv
// Valid/ready stream bundle between codeword producer, checker and data consumer.
interface hamming_checker_if #(
    parameter int P_BITS = 3
);
    import hamming_checker_pkg::*;

    localparam int CW_WIDTH   = cw_width(P_BITS);
    localparam int DATA_WIDTH = data_width(P_BITS);

    logic                  in_valid;
    logic                  in_ready;
    logic [CW_WIDTH-1:0]   in_code;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_single_err;
    logic                  out_double_err;
    logic [P_BITS-1:0]     out_err_pos;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_single_err, out_double_err, out_err_pos
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_single_err, out_double_err, out_err_pos
    );

endinterface

// File: rtl/hamming_syndrome.sv
// Combinational syndrome/parity of an extended Hamming codeword.
module hamming_syndrome
    import hamming_checker_pkg::*;
#(
    parameter int P_BITS = 3
) (
    input  logic [cw_width(P_BITS)-1:0] code,
    output logic [P_BITS-1:0]           syndrome,
    output logic                        parity
);

    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        syndrome = '0;
        for (int i = 1; i < cw_width(P_BITS); i++) begin
            if (code[i]) syndrome = syndrome ^ P_BITS'(i);
        end
        parity = ^code;
    end

endmodule

// File: rtl/hamming_checker.sv
// Two-stage pipelined SECDED decoder with valid/ready handshake.
// Optional saturating error counters when HAMMING_STATS_EN is defined.
module hamming_checker
    import hamming_checker_pkg::*;
#(
    parameter int P_BITS = 3
`ifdef HAMMING_STATS_EN
    , parameter int CNT_WIDTH = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef HAMMING_STATS_EN
    input  logic                 cnt_clr,
    output logic [CNT_WIDTH-1:0] sec_cnt,
    output logic [CNT_WIDTH-1:0] ded_cnt,
`endif
    hamming_checker_if.slave     bus
);

    localparam int DATA_WIDTH = data_width(P_BITS);

    logic [P_BITS-1:0]     syn_comb;
    logic                  par_comb;
    logic [DATA_WIDTH-1:0] raw_comb;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_raw;
    logic [P_BITS-1:0]     s1_syn;
    logic                  s1_par;
    logic                  s2_valid;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  in_fire;
    logic                  out_fire;
    err_class_e            cls;
    logic [DATA_WIDTH-1:0] data_comb;

    hamming_syndrome #(.P_BITS(P_BITS)) u_syndrome (
        .code     (bus.in_code),
        .syndrome (syn_comb),
        .parity   (par_comb)
    );

    assign s2_adv        = !s2_valid || bus.out_ready;
    assign s1_adv        = !s1_valid || s2_adv;
    assign bus.in_ready  = s1_adv && !rst;
    assign bus.out_valid = s2_valid;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = s2_valid && bus.out_ready;

    // Only data positions travel down the pipe; parity bits end at the syndrome.
    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_data
        assign raw_comb[k]  = bus.in_code[data_pos(P_BITS, k)];
        assign data_comb[k] = s1_raw[k] ^ (s1_par && (s1_syn == P_BITS'(data_pos(P_BITS, k))));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_raw <= raw_comb;
                s1_syn <= syn_comb;
                s1_par <= par_comb;
            end
        end
    end

    always_comb begin
        cls = CLEAN;
        if (s1_par)               cls = SINGLE;
        else if (s1_syn != '0)    cls = DOUBLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid           <= 1'b0;
            bus.out_data       <= '0;
            bus.out_single_err <= 1'b0;
            bus.out_double_err <= 1'b0;
            bus.out_err_pos    <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_data       <= data_comb;
                bus.out_single_err <= (cls == SINGLE);
                bus.out_double_err <= (cls == DOUBLE);
                bus.out_err_pos    <= s1_syn;
            end
        end
    end

`ifdef HAMMING_STATS_EN
    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (out_fire) begin
            if (bus.out_single_err && !(&sec_cnt)) sec_cnt <= sec_cnt + CNT_WIDTH'(1);
            if (bus.out_double_err && !(&ded_cnt)) ded_cnt <= ded_cnt + CNT_WIDTH'(1);
        end
    end
`else
    logic unused_fire;
    assign unused_fire = out_fire;
`endif

endmodule
